// File: rtl/ppi_mode0_io_port.sv
// ppi_mode0_io_port: clocked 8255-style PPI core restricted to mode 0 basic I/O.
// A control word at address 11 sets port directions or performs a port C bit set/reset.
module ppi_mode0_io_port #(
  parameter logic [7:0] RESET_CTRL = 8'h9B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] A,
  input  logic       WRITE,
  input  logic       READ,
  inout  wire  [7:0] DATA,
  inout  wire  [7:0] PortA,
  inout  wire  [7:0] PortB,
  inout  wire  [7:0] PortC
);

  logic [7:0] ctrl_q, ctrl_d;
  logic [7:0] outa_q, outa_d;
  logic [7:0] outb_q, outb_d;
  logic [7:0] outc_q, outc_d;

  logic       wr_s;
  logic       rd_s;
  logic       a_in_s;
  logic       b_in_s;
  logic       cu_in_s;
  logic       cl_in_s;
  logic [7:0] rdata_s;
  logic       rd_en_s;
  logic       unused_ctrl_s;

  // Both strobes low together is illegal and qualifies as neither access.
  assign wr_s = (WRITE == 1'b0) && (READ == 1'b1);
  assign rd_s = (READ == 1'b0) && (WRITE == 1'b1);

  // Direction bits: 1 = input (pins high-Z), 0 = output (latch driven).
  assign a_in_s  = ctrl_q[4];
  assign cu_in_s = ctrl_q[3];
  assign b_in_s  = ctrl_q[1];
  assign cl_in_s = ctrl_q[0];

  // Mode-select bits are stored for completeness but never change behaviour.
  assign unused_ctrl_s = ^{ctrl_q[7:5], ctrl_q[2]};

  // Next-state decode for the control register and the three output latches.
  always_comb begin
    ctrl_d = ctrl_q;
    outa_d = outa_q;
    outb_d = outb_q;
    outc_d = outc_q;
    if (wr_s) begin
      case (A)
        2'b00: outa_d = DATA;
        2'b01: outb_d = DATA;
        2'b10: outc_d = DATA;
        2'b11: begin
          if (DATA[7]) begin
            ctrl_d = DATA;
            outa_d = 8'h00;
            outb_d = 8'h00;
            outc_d = 8'h00;
          end else begin
            outc_d[DATA[3:1]] = DATA[0];
          end
        end
        default: begin
          ctrl_d = ctrl_q;
        end
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // State registers; reset takes priority over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= RESET_CTRL;
      outa_q <= 8'h00;
      outb_q <= 8'h00;
      outc_q <= 8'h00;
    end else begin
      ctrl_q <= ctrl_d;
      outa_q <= outa_d;
      outb_q <= outb_d;
      outc_q <= outc_d;
    end
  end

  assign PortA      = a_in_s  ? 8'hzz : outa_q;
  assign PortB      = b_in_s  ? 8'hzz : outb_q;
  assign PortC[7:4] = cu_in_s ? 4'hz  : outc_q[7:4];
  assign PortC[3:0] = cl_in_s ? 4'hz  : outc_q[3:0];

  // Combinational read mux: input groups return pins, output groups return latches.
  always_comb begin
    rdata_s = 8'h00;
    rd_en_s = 1'b0;
    if (rd_s) begin
      case (A)
        2'b00: begin
          rd_en_s = 1'b1;
          rdata_s = a_in_s ? PortA : outa_q;
        end
        2'b01: begin
          rd_en_s = 1'b1;
          rdata_s = b_in_s ? PortB : outb_q;
        end
        2'b10: begin
          rd_en_s = 1'b1;
          rdata_s = {(cu_in_s ? PortC[7:4] : outc_q[7:4]),
                     (cl_in_s ? PortC[3:0] : outc_q[3:0])};
        end
        default: begin
          rd_en_s = 1'b0;
          rdata_s = 8'h00;
        end
      endcase
    end else begin
      rd_en_s = 1'b0;
      rdata_s = 8'h00;
    end
  end

  assign DATA = rd_en_s ? rdata_s : 8'hzz;

endmodule

// File: tb/tb_ppi_mode0_io_port.sv
// tb_ppi_mode0_io_port: directed self-checking bench for ppi_mode0_io_port.
// The bench owns every external driver on DATA and the peripheral pins.
module tb_ppi_mode0_io_port;

  logic       clk;
  logic       reset;
  logic [1:0] A;
  logic       WRITE;
  logic       READ;
  wire  [7:0] DATA;
  wire  [7:0] PortA;
  wire  [7:0] PortB;
  wire  [7:0] PortC;

  logic       d_en;
  logic [7:0] d_val;
  logic       pa_en;
  logic [7:0] pa_val;
  logic       pb_en;
  logic [7:0] pb_val;
  logic       pch_en;
  logic       pcl_en;
  logic [7:0] pc_val;
  logic [7:0] rd_v;

  int n_total;
  int n_bad;

  assign DATA       = d_en   ? d_val       : 8'hzz;
  assign PortA      = pa_en  ? pa_val      : 8'hzz;
  assign PortB      = pb_en  ? pb_val      : 8'hzz;
  assign PortC[7:4] = pch_en ? pc_val[7:4] : 4'hz;
  assign PortC[3:0] = pcl_en ? pc_val[3:0] : 4'hz;

  ppi_mode0_io_port #(.RESET_CTRL(8'h9B)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .WRITE (WRITE),
    .READ  (READ),
    .DATA  (DATA),
    .PortA (PortA),
    .PortB (PortB),
    .PortC (PortC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [7:0] val);
    @(negedge clk);
    A     = addr;
    d_val = val;
    d_en  = 1'b1;
    READ  = 1'b1;
    WRITE = 1'b0;
    @(posedge clk);
    #1;
    WRITE = 1'b1;
    d_en  = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] addr, output logic [7:0] val);
    @(negedge clk);
    A     = addr;
    WRITE = 1'b1;
    READ  = 1'b0;
    #1;
    val   = DATA;
    READ  = 1'b1;
  endtask

  task automatic release_pins();
    pa_en  = 1'b0;
    pb_en  = 1'b0;
    pch_en = 1'b0;
    pcl_en = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    A       = 2'b00;
    WRITE   = 1'b1;
    READ    = 1'b1;
    d_en    = 1'b0;
    d_val   = 8'h00;
    pa_val  = 8'h00;
    pb_val  = 8'h00;
    pc_val  = 8'h00;
    release_pins();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state: every group is an input, so reads see external pins.
    check("reset_ctrl", dut.ctrl_q, 8'h9B);
    pa_en = 1'b1; pa_val = 8'h5A;
    pb_en = 1'b1; pb_val = 8'h33;
    pch_en = 1'b1; pcl_en = 1'b1; pc_val = 8'h96;
    do_read(2'b00, rd_v); check("reset_rd_a", rd_v, 8'h5A);
    do_read(2'b01, rd_v); check("reset_rd_b", rd_v, 8'h33);
    do_read(2'b10, rd_v); check("reset_rd_c", rd_v, 8'h96);
    release_pins();

    // Writes to an input port land in the latch only.
    do_write(2'b11, 8'h9B);
    do_write(2'b00, 8'd7);
    do_write(2'b00, 8'd14);
    pa_en = 1'b1; pa_val = 8'hE1;
    do_read(2'b00, rd_v); check("in_rd_a_pins", rd_v, 8'hE1);
    check("in_latch_a", dut.outa_q, 8'h0E);
    release_pins();

    // All ports output.
    do_write(2'b11, 8'h80);
    do_write(2'b00, 8'h3C); check("out_pin_a", PortA, 8'h3C);
    do_write(2'b01, 8'hA5); check("out_pin_b", PortB, 8'hA5);
    do_write(2'b10, 8'h0F); check("out_pin_c", PortC, 8'h0F);
    do_read(2'b00, rd_v); check("out_rd_a", rd_v, 8'h3C);
    do_read(2'b01, rd_v); check("out_rd_b", rd_v, 8'hA5);
    do_read(2'b10, rd_v); check("out_rd_c", rd_v, 8'h0F);

    // A mode-set write clears every latch.
    do_write(2'b11, 8'h80);
    check("modeset_clr_a", PortA, 8'h00);
    check("modeset_clr_c", PortC, 8'h00);

    // Bit set/reset on port C.
    do_write(2'b11, 8'h0B); check("bsr_set5", PortC, 8'h20);
    do_write(2'b11, 8'h0A); check("bsr_clr5", PortC, 8'h00);
    do_write(2'b11, 8'h0F); check("bsr_set7", PortC, 8'h80);
    do_write(2'b11, 8'h01); check("bsr_set0", PortC, 8'h81);
    check("bsr_ctrl_kept", dut.ctrl_q, 8'h80);

    // 0x88: C upper input, C lower output, A and B output.
    do_write(2'b11, 8'h88);
    do_write(2'b10, 8'h05);
    pch_en = 1'b1; pc_val = 8'hC0;
    #1;
    check("split_pin_lo", {4'h0, PortC[3:0]}, 8'h05);
    do_read(2'b10, rd_v); check("split_rd_c", rd_v, 8'hC5);
    do_write(2'b11, 8'h0F);
    check("split_latch_hi", dut.outc_q, 8'h85);
    do_read(2'b10, rd_v); check("split_rd_c2", rd_v, 8'hC5);
    release_pins();

    // Both strobes low: no state change and DATA left to the bench.
    do_write(2'b11, 8'h80);
    do_write(2'b00, 8'h3C);
    @(negedge clk);
    A = 2'b00; d_val = 8'h00; d_en = 1'b1;
    WRITE = 1'b0; READ = 1'b0;
    @(posedge clk);
    #1;
    check("illegal_pin_a", PortA, 8'h3C);
    check("illegal_data", DATA, 8'h00);
    WRITE = 1'b1; READ = 1'b1; d_en = 1'b0;

    // A write held over several edges behaves like one write.
    @(negedge clk);
    A = 2'b01; d_val = 8'h5A; d_en = 1'b1;
    WRITE = 1'b0; READ = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    WRITE = 1'b1; d_en = 1'b0;
    check("held_wr_b", PortB, 8'h5A);

    // Reset wins over a coincident mode-set write.
    @(negedge clk);
    A = 2'b11; d_val = 8'h80; d_en = 1'b1;
    WRITE = 1'b0; READ = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; WRITE = 1'b1; d_en = 1'b0;
    check("rst_wr_ctrl", dut.ctrl_q, 8'h9B);
    check("rst_wr_outa", dut.outa_q, 8'h00);
    check("rst_wr_outb", dut.outb_q, 8'h00);
    pa_en = 1'b1; pa_val = 8'h12;
    do_read(2'b00, rd_v); check("rst_wr_rd_a", rd_v, 8'h12);
    release_pins();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
